// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
//   Bundle between the ID stage, register file, WB stage and the ID/EX pipeline
//   register.
//   slave  : the ID/EX register. It takes in the ID fields, the WB write port
//            and flush. It drives the registered EX fields, stall and stall_cnt.
//   master : the surrounding pipeline (or a testbench). Same signals, with the
//            directions reversed.
// ----------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // ID side
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rdata1;
    logic [XLEN-1:0] id_rdata2;
    logic [XLEN-1:0] id_imm;
    logic [8:0]      id_ctrl;   // {reg_write,mem_read,mem_write,mem_to_reg,alu_src,branch,alu_op[2:0]}
    // WB write port (for same-cycle bypass)
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    // EX redirect
    logic            flush;
    // Outputs
    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_rdata1;
    logic [XLEN-1:0]  ex_rdata2;
    logic [8:0]       ex_ctrl;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rdata1, id_rdata2, id_imm, id_ctrl,
               wb_reg_write, wb_rd, wb_data, flush,
        output stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_rdata1, ex_rdata2, ex_ctrl, stall_cnt
    );

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_rdata1, id_rdata2, id_imm, id_ctrl,
               wb_reg_write, wb_rd, wb_data, flush,
        input  stall, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_rdata1, ex_rdata2, ex_ctrl, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage RISC-V core.
//   - Captures the ID instruction fields and both operands. The capture is one
//     cycle long.
//   - When the WB stage writes a source register in the same cycle, the WB
//     data is captured in place of the stale register-file read.
//   - Detects a load-use hazard against the instruction in EX. It raises stall
//     and inserts a bubble.
//   - A flush from EX squashes the ID instruction.
//   - Counts stall cycles in a saturating counter.
// Ports
//   i_clk    : core clock, rising edge
//   i_reset  : asynchronous, active-high, clears all state
//   io_bus   : id_ex_stage_if.slave
//              inputs  : ID fields, WB write port, flush
//              outputs : ex_* fields, stall, stall_cnt
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    id_ex_stage_if.slave  io_bus
);
    localparam int CTRL_MEM_READ = 7;

    logic                      r_valid;
    logic [8:0]                r_ctrl;
    logic [XLEN-1:0]           r_pc;
    logic [XLEN-1:0]           r_imm;
    logic [1:0][4:0]           r_rs;
    logic [4:0]                r_rd;
    logic [1:0][XLEN-1:0]      r_rdata;
    logic [CNT_W-1:0]          r_stall_cnt;

    logic                      w_stall;
    logic                      w_bubble;
    logic [1:0][4:0]           w_rs;
    logic [1:0]                w_use;
    logic [1:0][XLEN-1:0]      w_rdata_in;
    logic [1:0][XLEN-1:0]      w_opnd;
    logic [1:0]                w_hit;

    assign w_rs       = {io_bus.id_rs2,     io_bus.id_rs1};
    assign w_use      = {io_bus.id_use_rs2, io_bus.id_use_rs1};
    assign w_rdata_in = {io_bus.id_rdata2,  io_bus.id_rdata1};

    // Per-operand hazard match and WB bypass. A register index of x0 never
    // matches: x0 cannot be a load target and cannot be a bypass destination.
    for (genvar g = 0; g < 2; g++) begin : g_opnd
        assign w_hit[g]  = w_use[g] && (w_rs[g] == r_rd);
        assign w_opnd[g] = (io_bus.wb_reg_write && (io_bus.wb_rd != 5'd0) &&
                            (io_bus.wb_rd == w_rs[g])) ? io_bus.wb_data : w_rdata_in[g];
    end

    // The stall lasts one cycle. The bubble it inserts clears ex_ctrl.mem_read,
    // so the hazard term is gone on the following cycle.
    assign w_stall  = r_valid && r_ctrl[CTRL_MEM_READ] && (r_rd != 5'd0) &&
                      io_bus.id_valid && (|w_hit);
    assign w_bubble = io_bus.flush || w_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rd    <= '0;
            r_rdata <= '0;
        end else if (w_bubble) begin
            // Only valid and ctrl are cleared. The data fields hold their
            // values because nothing consumes them while ex_valid is 0.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= io_bus.id_valid;
            r_ctrl  <= io_bus.id_valid ? io_bus.id_ctrl : 9'd0;
            r_pc    <= io_bus.id_pc;
            r_imm   <= io_bus.id_imm;
            r_rs    <= w_rs;
            r_rd    <= io_bus.id_rd;
            r_rdata <= w_opnd;
        end
    end

    // The counter skips cycles where flush is also high. The flush already
    // discards the stalled instruction, so that cycle is not a stall cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_stall_cnt <= '0;
        else if (w_stall && !io_bus.flush && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign io_bus.stall     = w_stall;
    assign io_bus.ex_valid  = r_valid;
    assign io_bus.ex_ctrl   = r_ctrl;
    assign io_bus.ex_pc     = r_pc;
    assign io_bus.ex_imm    = r_imm;
    assign io_bus.ex_rs1    = r_rs[0];
    assign io_bus.ex_rs2    = r_rs[1];
    assign io_bus.ex_rd     = r_rd;
    assign io_bus.ex_rdata1 = r_rdata[0];
    assign io_bus.ex_rdata2 = r_rdata[1];
    assign io_bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [8:0] C_LW  = 9'h1B0;  // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [8:0] C_ADD = 9'h100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) ifc ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (ifc.slave)
    );

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
    } ex_t;

    ex_t              sb[$];
    ex_t              mdl;
    logic [CNT_W-1:0] mcnt;
    int               nerr = 0;
    int               nchk = 0;

    function automatic ex_t snap();
        ex_t s;
        s.valid = ifc.ex_valid;  s.ctrl = ifc.ex_ctrl;
        s.pc    = ifc.ex_pc;     s.imm  = ifc.ex_imm;
        s.rs1   = ifc.ex_rs1;    s.rs2  = ifc.ex_rs2;  s.rd = ifc.ex_rd;
        s.d1    = ifc.ex_rdata1; s.d2   = ifc.ex_rdata2;
        return s;
    endfunction

    function automatic logic model_stall();
        return mdl.valid && mdl.ctrl[7] && (mdl.rd != 5'd0) && ifc.id_valid &&
               ((ifc.id_use_rs1 && ifc.id_rs1 == mdl.rd) ||
                (ifc.id_use_rs2 && ifc.id_rs2 == mdl.rd));
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [8:0] ctrl);
        ifc.id_valid = v;     ifc.id_pc = pc;
        ifc.id_rs1 = rs1;     ifc.id_rs2 = rs2;
        ifc.id_use_rs1 = u1;  ifc.id_use_rs2 = u2;
        ifc.id_rd = rd;       ifc.id_rdata1 = d1;  ifc.id_rdata2 = d2;
        ifc.id_imm = imm;     ifc.id_ctrl = ctrl;
        #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        ifc.wb_reg_write = we; ifc.wb_rd = rd; ifc.wb_data = data;
        #1;
    endtask

    // Predict the next EX contents from the inputs currently driven, queue
    // the prediction, then advance one clock.
    task automatic step();
        ex_t  n;
        logic st;
        n  = mdl;
        st = model_stall();
        if (ifc.flush || st) begin
            n.valid = 1'b0;
            n.ctrl  = 9'd0;
        end else begin
            n.valid = ifc.id_valid;
            n.ctrl  = ifc.id_valid ? ifc.id_ctrl : 9'd0;
            n.pc    = ifc.id_pc;   n.imm = ifc.id_imm;
            n.rs1   = ifc.id_rs1;  n.rs2 = ifc.id_rs2;  n.rd = ifc.id_rd;
            n.d1 = (ifc.wb_reg_write && ifc.wb_rd != 5'd0 && ifc.wb_rd == ifc.id_rs1) ?
                   ifc.wb_data : ifc.id_rdata1;
            n.d2 = (ifc.wb_reg_write && ifc.wb_rd != 5'd0 && ifc.wb_rd == ifc.id_rs2) ?
                   ifc.wb_data : ifc.id_rdata2;
        end
        if (st && !ifc.flush && mcnt != {CNT_W{1'b1}}) mcnt = mcnt + 1'b1;
        mdl = n;
        sb.push_back(n);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ex_t got;
        reset = 1'b1;
        wb(1'b1, 5'd3, 32'hFFFF_0000);
        drive(1'b1, 32'hAAAA_5554, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 32'h1, 32'h2, 32'h3, 9'h1FF);
        repeat (2) @(posedge clk);
        #1;
        got = snap();
        nchk++;
        if (got !== '0) begin nerr++; $display("FAIL reset_ex got=%h exp=0", got); end
        nchk++;
        if (ifc.stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got=%b exp=0", ifc.stall); end
        nchk++;
        if (ifc.stall_cnt !== '0) begin nerr++; $display("FAIL reset_cnt got=%0d exp=0", ifc.stall_cnt); end
        reset = 1'b0;
        mdl = '0; mcnt = '0; sb.delete();
        wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_capture();
        ex_t got, e;
        drive(1'b1, 32'h100, 5'd2, 5'd3, 1'b1, 1'b1, 5'd1, 32'd5, 32'd7, 32'h10, 9'h1A0);
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e) begin nerr++; $display("FAIL capture_basic got=%h exp=%h", got, e); end
        nchk++;
        if (ifc.ex_rdata1 !== 32'd5 || ifc.ex_rdata2 !== 32'd7 || ifc.ex_ctrl !== 9'h1A0 || ifc.ex_valid !== 1'b1) begin
            nerr++;
            $display("FAIL capture_fields got=%h/%h/%h/%b exp=5/7/1a0/1",
                     ifc.ex_rdata1, ifc.ex_rdata2, ifc.ex_ctrl, ifc.ex_valid);
        end
        // Next instruction, then an invalid slot whose ctrl must be dropped.
        drive(1'b1, 32'h104, 5'd6, 5'd7, 1'b1, 1'b1, 5'd8, 32'h11, 32'h22, 32'hFFFF_FFFC, 9'h10A);
        step();
        drive(1'b0, 32'h108, 5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 32'h33, 32'h44, 32'h8, 9'h1FF);
        step();
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            if (i == 1) got = snap();
            else        got = e;  // first entry is superseded by the second edge
            if (i == 1) begin
                nchk++;
                if (got !== e) begin nerr++; $display("FAIL capture_invalid got=%h exp=%h", got, e); end
            end
        end
    endtask

    task automatic test_load_use();
        ex_t got, e;
        logic [CNT_W-1:0] c0;
        c0 = mcnt;
        drive(1'b1, 32'h200, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h40, 32'h0, 32'h4, C_LW);
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e) begin nerr++; $display("FAIL lu_load got=%h exp=%h", got, e); end
        drive(1'b1, 32'h204, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 32'h55, 32'h66, 32'h0, C_ADD);
        nchk++;
        if (ifc.stall !== 1'b1) begin nerr++; $display("FAIL lu_stall got=%b exp=1", ifc.stall); end
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_valid !== 1'b0) begin nerr++; $display("FAIL lu_bubble got=%h exp=%h", got, e); end
        nchk++;
        if (ifc.stall_cnt !== c0 + 1'b1) begin nerr++; $display("FAIL lu_cnt got=%0d exp=%0d", ifc.stall_cnt, c0 + 1'b1); end
        nchk++;
        if (ifc.stall !== 1'b0) begin nerr++; $display("FAIL lu_stall_drop got=%b exp=0", ifc.stall); end
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_pc !== 32'h204) begin nerr++; $display("FAIL lu_add got=%h exp=%h", got, e); end
        // Load to x0, use_rs1=0 and an rs2 hazard.
        drive(1'b1, 32'h300, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
        step(); void'(sb.pop_front());
        drive(1'b1, 32'h304, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, C_ADD);
        nchk++;
        if (ifc.stall !== 1'b0) begin nerr++; $display("FAIL lu_rd0 got=%b exp=0", ifc.stall); end
        drive(1'b1, 32'h308, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
        step(); void'(sb.pop_front());
        drive(1'b1, 32'h30C, 5'd5, 5'd2, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, C_ADD);
        nchk++;
        if (ifc.stall !== 1'b0) begin nerr++; $display("FAIL lu_nouse got=%b exp=0", ifc.stall); end
        step(); void'(sb.pop_front());
        drive(1'b1, 32'h310, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0, 32'h0, C_LW);
        step(); void'(sb.pop_front());
        drive(1'b1, 32'h314, 5'd3, 5'd9, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0, 32'h0, C_ADD);
        nchk++;
        if (ifc.stall !== 1'b1) begin nerr++; $display("FAIL lu_rs2 got=%b exp=1", ifc.stall); end
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e) begin nerr++; $display("FAIL lu_rs2_bubble got=%h exp=%h", got, e); end
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e) begin nerr++; $display("FAIL lu_rs2_add got=%h exp=%h", got, e); end
    endtask

    task automatic test_bypass();
        ex_t got, e;
        wb(1'b1, 5'd4, 32'hDEAD_BEEF);
        drive(1'b1, 32'h400, 5'd0, 5'd4, 1'b1, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e) begin nerr++; $display("FAIL byp_rs2 got=%h exp=%h", got, e); end
        nchk++;
        if (ifc.ex_rdata2 !== 32'hDEAD_BEEF || ifc.ex_rdata1 !== 32'h0) begin
            nerr++; $display("FAIL byp_vals got=%h/%h exp=deadbeef/0", ifc.ex_rdata2, ifc.ex_rdata1);
        end
        wb(1'b1, 5'd0, 32'h1234_5678);
        drive(1'b1, 32'h404, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, C_ADD);
        step();
        nchk++;
        if (ifc.ex_rdata1 !== 32'h0) begin nerr++; $display("FAIL byp_x0 got=%h exp=0", ifc.ex_rdata1); end
        void'(sb.pop_front());
        wb(1'b1, 5'd12, 32'hCAFE_F00D);
        drive(1'b1, 32'h408, 5'd12, 5'd12, 1'b1, 1'b1, 5'd3, 32'h1, 32'h2, 32'h0, C_ADD);
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e) begin nerr++; $display("FAIL byp_both got=%h exp=%h", got, e); end
        wb(1'b0, 5'd12, 32'hCAFE_F00D);
        drive(1'b1, 32'h40C, 5'd12, 5'd12, 1'b1, 1'b1, 5'd3, 32'h1, 32'h2, 32'h0, C_ADD);
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_rdata1 !== 32'h1) begin nerr++; $display("FAIL byp_nowrite got=%h exp=%h", got, e); end
        wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_flush();
        ex_t got, e;
        logic [CNT_W-1:0] c0;
        drive(1'b1, 32'h500, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
        step(); void'(sb.pop_front());
        c0 = ifc.stall_cnt;
        drive(1'b1, 32'h504, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 32'h0, 32'h0, 32'h0, C_ADD);
        ifc.flush = 1'b1; #1;
        nchk++;
        if (ifc.stall !== 1'b1) begin nerr++; $display("FAIL fl_stall got=%b exp=1", ifc.stall); end
        step();
        ifc.flush = 1'b0;
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_valid !== 1'b0 || ifc.ex_ctrl !== 9'd0) begin
            nerr++; $display("FAIL fl_bubble got=%h exp=%h", got, e);
        end
        nchk++;
        if (ifc.stall_cnt !== c0) begin nerr++; $display("FAIL fl_cnt got=%0d exp=%0d", ifc.stall_cnt, c0); end
        drive(1'b1, 32'h508, 5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 32'h7, 32'h8, 32'h0, C_ADD);
        ifc.flush = 1'b1; #1;
        step();
        ifc.flush = 1'b0;
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_valid !== 1'b0) begin nerr++; $display("FAIL fl_plain got=%h exp=%h", got, e); end
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_valid !== 1'b1) begin nerr++; $display("FAIL fl_resume got=%h exp=%h", got, e); end
    endtask

    task automatic test_saturation();
        ex_t got, e;
        // lw x5,0(x5) back to back: every other cycle is a load-use stall.
        drive(1'b1, 32'h600, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
        for (int i = 0; i < 40; i++) begin
            step();
            got = snap(); e = sb.pop_front();
            nchk++;
            if (got !== e || ifc.stall_cnt !== mcnt) begin
                nerr++; $display("FAIL sat_step%0d got=%h cnt=%0d exp=%h cnt=%0d", i, got, ifc.stall_cnt, e, mcnt);
            end
        end
        nchk++;
        if (ifc.stall_cnt !== 4'd15) begin nerr++; $display("FAIL sat_final got=%0d exp=15", ifc.stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        ex_t got, e;
        drive(1'b1, 32'h700, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, C_ADD);
        step(); void'(sb.pop_front());
        drive(1'b1, 32'h704, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
        step(); void'(sb.pop_front());
        drive(1'b1, 32'h708, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 32'h0, 32'h0, 32'h0, C_ADD);
        nchk++;
        if (ifc.stall !== 1'b1) begin nerr++; $display("FAIL rst_pre_stall got=%b exp=1", ifc.stall); end
        reset = 1'b1; #1;
        got = snap();
        nchk++;
        if (ifc.stall !== 1'b0 || got !== '0 || ifc.stall_cnt !== '0) begin
            nerr++; $display("FAIL rst_async got=%h stall=%b cnt=%0d exp=0", got, ifc.stall, ifc.stall_cnt);
        end
        @(posedge clk); #1;
        got = snap();
        nchk++;
        if (got !== '0) begin nerr++; $display("FAIL rst_hold got=%h exp=0", got); end
        reset = 1'b0;
        mdl = '0; mcnt = '0; sb.delete();
        step();
        got = snap(); e = sb.pop_front();
        nchk++;
        if (got !== e || ifc.ex_pc !== 32'h708) begin nerr++; $display("FAIL rst_release got=%h exp=%h", got, e); end
    endtask

    initial begin
        ifc.flush = 1'b0;
        ifc.wb_reg_write = 1'b0; ifc.wb_rd = '0; ifc.wb_data = '0;
        mdl = '0; mcnt = '0;
        test_reset();
        test_capture();
        test_load_use();
        test_bypass();
        test_flush();
        test_saturation();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
